// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CHK_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_CHK       = 3'd4
   } state_t;

   // (a + b) mod n for a < n, b < n
   function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                            input int unsigned n);
      int unsigned s;
      s = a + b;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned cand;
         cand = wrap_add(32'(ptr), k, N_REQ);
         if (!any && req[IDX_W'(cand)]) begin
            any                 = 1'b1;
            grant[IDX_W'(cand)] = 1'b1;
            idx                 = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet scheduler multiplexing N_REQ byte streams onto one UART transmitter.
// Define UART_TX_SCHED_CHKSUM_EN to append an XOR checksum byte to every packet.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_data_valid,
   input  logic                 tx_data_ready,
   output logic [IDX_W-1:0]     grant_id,
   output logic                 busy
);

   logic [N_REQ-1:0][BYTE_W-1:0] req_bytes;
   logic [N_REQ-1:0]             arb_grant;
   logic [IDX_W-1:0]             arb_idx;
   logic                         arb_any;

   state_t                       state;
   logic [IDX_W-1:0]             rr_ptr;
   logic [N_REQ-1:0]             grant_oh;
   logic                         last_flag;
`ifdef UART_TX_SCHED_CHKSUM_EN
   logic [CHK_W-1:0]             acc;
   logic                         chk_sent;
`endif

   assign req_bytes = req_data;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Owner is locked from grant until its last byte (and checksum) leaves the line.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         grant_id      <= '0;
         grant_oh      <= '0;
         busy          <= 1'b0;
         tx_data_valid <= 1'b0;
         tx_data       <= 8'h00;
         req_ready     <= '0;
         last_flag     <= 1'b0;
`ifdef UART_TX_SCHED_CHKSUM_EN
         acc           <= '0;
         chk_sent      <= 1'b0;
`endif
      end else begin
         tx_data_valid <= 1'b0;
         req_ready     <= '0;
         case (state)
            S_IDLE: begin
               if (arb_any) begin
                  grant_id <= arb_idx;
                  grant_oh <= arb_grant;
                  busy     <= 1'b1;
                  state    <= S_ISSUE;
`ifdef UART_TX_SCHED_CHKSUM_EN
                  acc      <= '0;
                  chk_sent <= 1'b0;
`endif
               end
            end
            S_ISSUE: begin
               if (tx_data_ready && req_valid[grant_id]) begin
                  tx_data_valid <= 1'b1;
                  tx_data       <= req_bytes[grant_id];
                  req_ready     <= grant_oh;
                  last_flag     <= req_last[grant_id];
`ifdef UART_TX_SCHED_CHKSUM_EN
                  acc           <= acc ^ req_bytes[grant_id];
`endif
                  state         <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (!tx_data_ready) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (tx_data_ready) begin
                  if (!last_flag) begin
                     state <= S_ISSUE;
                  end
`ifdef UART_TX_SCHED_CHKSUM_EN
                  else if (!chk_sent) begin
                     state <= S_CHK;
                  end
`endif
                  else begin
                     state  <= S_IDLE;
                     busy   <= 1'b0;
                     rr_ptr <= IDX_W'(wrap_add(32'(grant_id), 32'd1, N_REQ));
                  end
               end
            end
`ifdef UART_TX_SCHED_CHKSUM_EN
            // Trailer byte is ours, so no requester sees an accept for it.
            S_CHK: begin
               if (tx_data_ready) begin
                  tx_data_valid <= 1'b1;
                  tx_data       <= acc;
                  chk_sent      <= 1'b1;
                  state         <= S_WAIT_BUSY;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: queue-based requester/transmitter models and a packet-level scoreboard.
module tb_uart_tx_sched;

   localparam int N = 4;
`ifdef UART_TX_SCHED_CHKSUM_EN
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_data_valid;
   logic           tx_data_ready = 1'b1;
   logic [1:0]     grant_id;
   logic           busy;

   always #5 clk = ~clk;

   uart_tx_sched #(.N_REQ(N), .IDX_W(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   // Requester byte queues: data and last flag, head = next byte to present
   logic [7:0] qd [N][256];
   logic       ql [N][256];
   int         head [N];
   int         tail [N];
   logic       stall [N];

   // Scoreboard state
   int         m_ptr, m_owner;
   bit         m_inpkt, m_chk_pend;
   logic [7:0] m_acc, last_chk;
   int         tx_hold, hold_force, rise_cyc, cyc, n_valid, n_rdy0;
   int         dut_grants[$];
   logic [7:0] tx_log[$];
   int         checks = 0;
   int         failures = 0;

   task automatic clear_queues();
      for (int i = 0; i < N; i++) begin
         head[i] = 0; tail[i] = 0; stall[i] = 1'b0;
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      qd[r][tail[r]] = d;
      ql[r][tail[r]] = l;
      tail[r]++;
   endtask

   task automatic push_pkt(input int r, input int len);
      for (int k = 0; k < len; k++) push(r, 8'($urandom), k == len - 1);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (head[i] < tail[i]) begin
            req_valid[i]      = !stall[i];
            req_data[8*i +: 8] = qd[i][head[i]];
            req_last[i]       = ql[i][head[i]];
         end else begin
            req_valid[i]      = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
   endtask

   function automatic int pick_owner();
      for (int k = 0; k < N; k++) begin
         int r;
         r = (m_ptr + k) % N;
         if (head[r] < tail[r]) return r;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_inpkt = 0; m_chk_pend = 0; m_acc = 8'h00;
      tx_hold = 0; hold_force = 0; tx_data_ready = 1'b1;
   endtask

   // Compare one sampled cycle against the packet-level expectation
   task automatic observe(output bit issued);
      logic [N-1:0] exp_rdy;
      logic [7:0]   exp_byte;
      issued = 1'b0;
      if (tx_data_valid === 1'b1) begin
         issued = 1'b1;
         n_valid++;
         tx_log.push_back(tx_data);
         checks++;
         if (tx_data_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_while_tx_busy: tx_data_ready=%b required 1", tx_data_ready);
         end
         if (m_chk_pend) begin
            checks++;
            if (tx_data !== m_acc || req_ready !== '0) begin
               failures++;
               $display("FAIL checksum_byte: got data=%h req_ready=%b required data=%h req_ready=0000",
                        tx_data, req_ready, m_acc);
            end
            last_chk = tx_data;
            m_chk_pend = 0; m_inpkt = 0; m_ptr = (m_owner + 1) % N;
         end else begin
            if (!m_inpkt) begin
               m_owner = pick_owner();
               checks++;
               if (m_owner < 0) begin
                  failures++;
                  $display("FAIL unexpected_issue: got byte %h with no pending packet", tx_data);
                  return;
               end
               m_inpkt = 1; m_acc = 8'h00;
               dut_grants.push_back(int'(grant_id));
            end
            exp_byte = qd[m_owner][head[m_owner]];
            exp_rdy = '0;
            exp_rdy[m_owner] = 1'b1;
            checks++;
            if (grant_id !== 2'(m_owner)) begin
               failures++;
               $display("FAIL grant_id: got %0d required %0d", grant_id, m_owner);
            end
            checks++;
            if (tx_data !== exp_byte) begin
               failures++;
               $display("FAIL tx_data: got %h required %h (requester %0d)", tx_data, exp_byte, m_owner);
            end
            checks++;
            if (req_ready !== exp_rdy) begin
               failures++;
               $display("FAIL req_ready_pulse: got %b required %b", req_ready, exp_rdy);
            end
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_during_packet: got %b required 1", busy);
            end
            if (req_ready[0] === 1'b1) n_rdy0++;
            m_acc = m_acc ^ exp_byte;
            if (ql[m_owner][head[m_owner]]) begin
`ifdef UART_TX_SCHED_CHKSUM_EN
               m_chk_pend = 1;
`else
               m_inpkt = 0; m_ptr = (m_owner + 1) % N;
`endif
            end
            head[m_owner]++;
         end
      end else begin
         checks++;
         if (req_ready !== '0) begin
            failures++;
            $display("FAIL stray_req_ready: got %b required 0000", req_ready);
         end
      end
   endtask

   // One clock: sample, run transmitter model, update requester inputs
   task automatic step();
      bit iss;
      @(posedge clk);
      #1;
      cyc++;
      observe(iss);
      if (iss) begin
         tx_data_ready = 1'b0;
         tx_hold = (hold_force > 0) ? hold_force : int'($urandom_range(1, 5));
      end else if (tx_hold > 0) begin
         tx_hold--;
         if (tx_hold == 0) begin
            tx_data_ready = 1'b1;
            rise_cyc = cyc;
         end
      end
      drive_inputs();
   endtask

   function automatic bit drained();
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b0;
      return !m_inpkt && !m_chk_pend && tx_hold == 0 && busy === 1'b0;
   endfunction

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (!drained() && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (!drained()) begin
         failures++;
         $display("FAIL %s_timeout: not drained after %0d cycles", name, budget);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_queues();
      model_reset();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_queues();
      model_reset();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b required 0", tx_data_valid); end
      checks++;
      if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
      checks++;
      if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d required 0", grant_id); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
      clear_queues();
      tx_log.delete();
      n_valid = 0; n_rdy0 = 0;
      push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
      drive_inputs();
      drain("single", 300);
      checks++;
      if (n_valid !== 3 + CHK_EXTRA) begin failures++; $display("FAIL single_valid_count: got %0d required %0d", n_valid, 3 + CHK_EXTRA); end
      checks++;
      if (n_rdy0 !== 3) begin failures++; $display("FAIL single_ready_count: got %0d required 3", n_rdy0); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (tx_log.size() <= k || tx_log[k] !== exp_b[k]) begin
            failures++;
            $display("FAIL single_byte_order: byte %0d wrong, required %h", k, exp_b[k]);
         end
      end
      checks++;
      if (cyc !== rise_cyc + 1) begin
         failures++;
         $display("FAIL single_busy_fall: busy fell at cycle %0d required %0d", cyc, rise_cyc + 1);
      end
   endtask

   task automatic test_round_robin();
      int exp_g [5];
      exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
      do_reset();
      dut_grants.delete();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < N; r++) push_pkt(r, 1);
      drive_inputs();
      drain("round_robin", 500);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (dut_grants.size() <= k || dut_grants[k] !== exp_g[k]) begin
            failures++;
            $display("FAIL rr_grant_order: grant %0d wrong, required %0d", k, exp_g[k]);
         end
      end
   endtask

   task automatic test_hold_grant();
      int n = 0;
      int early = 0;
      clear_queues();
      dut_grants.delete();
      push_pkt(2, 3);
      drive_inputs();
      while (!m_inpkt && n < 50) begin step(); n++; end
      push_pkt(1, 2);
      drive_inputs();
      n = 0;
      while ((m_inpkt || m_chk_pend) && m_owner == 2 && n < 300) begin
         step();
         if (req_ready[1] === 1'b1) early++;
         n++;
      end
      checks++;
      if (early !== 0) begin failures++; $display("FAIL hold_grant_intrusion: req_ready[1] pulsed %0d times, required 0", early); end
      drain("hold_grant", 400);
      checks++;
      if (dut_grants.size() !== 2 || dut_grants[0] !== 2 || dut_grants[1] !== 1) begin
         failures++;
         $display("FAIL hold_grant_order: got %0d grants, required sequence 2,1", dut_grants.size());
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int stray = 0;
      clear_queues();
      push_pkt(0, 3);
      hold_force = 12;
      drive_inputs();
      while (!m_inpkt && n < 50) begin step(); n++; end
      repeat (4) step();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || req_ready !== '0 || busy !== 1'b0 || grant_id !== 2'd0) begin
         failures++;
         $display("FAIL midpkt_reset: got valid=%b data=%h ready=%b busy=%b gid=%0d required all zero",
                  tx_data_valid, tx_data, req_ready, busy, grant_id);
      end
      rst_n = 1'b1;
      model_reset();
      head[0] = 0;
      stall[0] = 1'b1;
      drive_inputs();
      repeat (8) begin
         step();
         if (tx_data_valid !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin failures++; $display("FAIL midpkt_reset_quiet: got %0d issues after reset, required 0", stray); end
      stall[0] = 1'b0;
      drive_inputs();
      drain("reset_restart", 300);
   endtask

   task automatic test_stall();
      int n = 0;
      int bad = 0;
      logic [1:0] gid;
      clear_queues();
      push_pkt(0, 3);
      drive_inputs();
      while (!m_inpkt && n < 50) begin step(); n++; end
      stall[0] = 1'b1;
      drive_inputs();
      gid = grant_id;
      repeat (100) begin
         step();
         if (tx_data_valid !== 1'b0 || grant_id !== gid || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles of 100, required 0", bad); end
      stall[0] = 1'b0;
      drive_inputs();
      drain("stall_resume", 300);
   endtask

   task automatic test_random();
      do_reset();
      for (int round = 0; round < 3; round++) begin
         int n = 0;
         clear_queues();
         for (int r = 0; r < N; r++)
            if ($urandom_range(0, 3) != 0)
               for (int p = 0; p < int'($urandom_range(1, 3)); p++) push_pkt(r, int'($urandom_range(1, 4)));
         drive_inputs();
         while (!drained() && n < 3000) begin
            for (int i = 0; i < N; i++) stall[i] = 1'b0;
            if (m_inpkt && !m_chk_pend && $urandom_range(0, 3) == 0) stall[m_owner] = 1'b1;
            drive_inputs();
            step();
            n++;
         end
         for (int i = 0; i < N; i++) stall[i] = 1'b0;
         checks++;
         if (!drained()) begin failures++; $display("FAIL random_timeout: round %0d not drained", round); end
      end
   endtask

`ifdef UART_TX_SCHED_CHKSUM_EN
   task automatic test_chksum();
      clear_queues();
      n_valid = 0; n_rdy0 = 0;
      push(0, 8'hA5, 1'b0); push(0, 8'h0F, 1'b1);
      drive_inputs();
      drain("chksum", 300);
      checks++;
      if (last_chk !== 8'hAA) begin failures++; $display("FAIL chksum_value: got %h required aa", last_chk); end
      checks++;
      if (n_valid !== 3 || n_rdy0 !== 2) begin
         failures++;
         $display("FAIL chksum_counts: got valid=%0d ready=%0d required 3 and 2", n_valid, n_rdy0);
      end
   endtask
`endif

   initial begin
      cyc = 0; rise_cyc = 0; n_valid = 0; n_rdy0 = 0; last_chk = 8'h00; m_owner = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_hold_grant();
      test_reset_mid();
      test_stall();
      test_random();
`ifdef UART_TX_SCHED_CHKSUM_EN
      test_chksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
